rw_mode_scheduler: RTL and testbench

Channel-level read/write mode scheduler that decides when the DQ bus switches between read and write bursts. It drives `channelMode` and `rankChanged` into the DQ turnaround grant logic and consumes its `DQTurnaroundFree` result. It gates CAS issue toward the channel controller using write-queue watermarks, burst limits and a write-starvation timer. One instance per channel sits between the read/write queues and the CAS arbiter.

---
 rtl/rw_mode_scheduler_if.sv | 30 +++
 rtl/rw_mode_scheduler.sv | 143 ++++++++++++++
 tb/tb_rw_mode_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rw_mode_scheduler_if.sv
// Queue/CAS-side signal bundle for one channel's read/write mode scheduler.
// No storage: pure wiring, zero latency.
// casAllow is the only backpressure: the CAS arbiter must not issue while it is low.
interface rw_mode_scheduler_if #(
  parameter int CW         = 6,
  parameter int RANK_WIDTH = 2
);
  logic [CW-1:0]         rdCount;
  logic [CW-1:0]         wrCount;
  logic [RANK_WIDTH-1:0] nextRdRank;
  logic                  casIssued;
  logic [RANK_WIDTH-1:0] casRank;
  logic                  DQTurnaroundFree;
  logic                  channelMode;
  logic                  rankChanged;
  logic                  casAllow;
  logic                  protocolError;

  // Queue/arbiter side drives occupancy and CAS events, sees the mode decision.
  modport master (
    output rdCount, wrCount, nextRdRank, casIssued, casRank, DQTurnaroundFree,
    input  channelMode, rankChanged, casAllow, protocolError
  );

  // Scheduler side.
  modport slave (
    input  rdCount, wrCount, nextRdRank, casIssued, casRank, DQTurnaroundFree,
    output channelMode, rankChanged, casAllow, protocolError
  );
endinterface

// File: rtl/rw_mode_scheduler.sv
// Channel read/write mode scheduler: picks DQ bus direction from watermarks, burst limit and write age.
// Switch decided combinationally in cycle N, mode flips at the end of N; first CAS in new mode at >= N+3.
// casAllow drops during the switch cycle and turnaround; a CAS issued while it is low flags protocolError.
module rw_mode_scheduler #(
  parameter int QUEUE_DEPTH  = 32,
  parameter int WR_HIGH_WM   = 24,
  parameter int WR_LOW_WM    = 8,
  parameter int MAX_WR_BURST = 16,
  parameter int WR_AGE_MAX   = 255,
  parameter int RANK_WIDTH   = 2,
  localparam int CW          = $clog2(QUEUE_DEPTH + 1)
) (
  input logic               clk,
  input logic               rst,
  rw_mode_scheduler_if.slave sched
);

  localparam int AW = $clog2(WR_AGE_MAX + 1);
  localparam int BW = $clog2(MAX_WR_BURST + 1);

  localparam logic [CW-1:0] HIGH_WM   = CW'(WR_HIGH_WM);
  localparam logic [CW-1:0] LOW_WM    = CW'(WR_LOW_WM);
  localparam logic [AW-1:0] AGE_MAX   = AW'(WR_AGE_MAX);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_WR_BURST);

  typedef enum logic [1:0] {
    READ  = 2'd0,
    RD2WR = 2'd1,
    WRITE = 2'd2,
    WR2RD = 2'd3
  } state_t;

  state_t                state;
  logic [1:0]            settle;
  logic [AW-1:0]         wrAge;
  logic [BW-1:0]         wrBurst;
  logic [RANK_WIDTH-1:0] lastWrRank;
  logic                  modeReg;
  logic                  rankChangedReg;
  logic                  protoErrReg;

  logic switchNow;
  logic casAllow;
  logic casAccept;
  logic settleDone;

  // Switch decision from registered state and current queue occupancy; all triggers share one action.
  always_comb begin
    switchNow = 1'b0;
    case (state)
      READ:    switchNow = (sched.wrCount >= HIGH_WM) ||
                           (wrAge >= AGE_MAX) ||
                           ((sched.rdCount == '0) && (sched.wrCount != '0));
      WRITE:   switchNow = (sched.rdCount != '0) &&
                           ((sched.wrCount <= LOW_WM) ||
                            (wrBurst >= BURST_MAX) ||
                            (sched.wrCount == '0));
      default: switchNow = 1'b0;
    endcase
  end

  assign casAllow  = ((state == READ) || (state == WRITE)) && sched.DQTurnaroundFree && !switchNow;
  assign casAccept = sched.casIssued && casAllow;
  // Settle reaches zero on this edge, so the active state is entered no earlier than N+3.
  assign settleDone = (settle <= 2'd1);

  // Mode FSM with registered outputs, turnaround settle timer and write age/burst bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= READ;
      settle         <= 2'd0;
      wrAge          <= '0;
      wrBurst        <= '0;
      lastWrRank     <= '0;
      modeReg        <= 1'b0;
      rankChangedReg <= 1'b0;
      protoErrReg    <= 1'b0;
    end else begin
      if (sched.casIssued && !casAllow) begin
        protoErrReg <= 1'b1;
      end
      case (state)
        READ: begin
          if (sched.wrCount == '0) begin
            wrAge <= '0;
          end else if (wrAge < AGE_MAX) begin
            wrAge <= wrAge + 1'b1;
          end
          if (switchNow) begin
            state          <= RD2WR;
            settle         <= 2'd2;
            modeReg        <= 1'b1;
            rankChangedReg <= 1'b0;
            wrBurst        <= '0;
          end
        end
        RD2WR: begin
          if (settle != 2'd0) begin
            settle <= settle - 2'd1;
          end
          if (settleDone && sched.DQTurnaroundFree) begin
            state <= WRITE;
            wrAge <= '0;
          end else if (sched.wrCount == '0) begin
            wrAge <= '0;
          end
        end
        WRITE: begin
          if (casAccept) begin
            lastWrRank <= sched.casRank;
            if (wrBurst < BURST_MAX) begin
              wrBurst <= wrBurst + 1'b1;
            end
          end
          if (switchNow) begin
            state          <= WR2RD;
            settle         <= 2'd2;
            modeReg        <= 1'b0;
            rankChangedReg <= (sched.nextRdRank != lastWrRank);
            wrAge          <= '0;
          end
        end
        default: begin
          if (settle != 2'd0) begin
            settle <= settle - 2'd1;
          end
          if (sched.wrCount == '0) begin
            wrAge <= '0;
          end
          if (settleDone && sched.DQTurnaroundFree) begin
            state <= READ;
          end
        end
      endcase
    end
  end

  assign sched.channelMode   = modeReg;
  assign sched.rankChanged   = rankChangedReg;
  assign sched.casAllow      = casAllow;
  assign sched.protocolError = protoErrReg;

endmodule

// File: tb/tb_rw_mode_scheduler.sv
// Directed bench for rw_mode_scheduler: reset, watermarks, burst limit, starvation, illegal CAS, reset mid-turnaround.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after it.
// Each scenario task carries its own hand-computed expectations.
module tb_rw_mode_scheduler;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  rw_mode_scheduler_if #(.CW(6), .RANK_WIDTH(2)) schedIf ();

  rw_mode_scheduler dut (
    .clk   (clk),
    .rst   (rst),
    .sched (schedIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    schedIf.rdCount = '0;
    schedIf.wrCount = '0;
    schedIf.nextRdRank = '0;
    schedIf.casIssued = 1'b0;
    schedIf.casRank = '0;
    schedIf.DQTurnaroundFree = 1'b1;
    #2;
    compared++;
    if (schedIf.channelMode !== 1'b0) begin
      mismatched++; $display("FAIL reset_mode: got %b want 0", schedIf.channelMode);
    end
    compared++;
    if (schedIf.rankChanged !== 1'b0) begin
      mismatched++; $display("FAIL reset_rankChanged: got %b want 0", schedIf.rankChanged);
    end
    compared++;
    if (schedIf.protocolError !== 1'b0) begin
      mismatched++; $display("FAIL reset_protocolError: got %b want 0", schedIf.protocolError);
    end
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(); #1;
      compared++;
      if (schedIf.channelMode !== 1'b0 || schedIf.casAllow !== 1'b1) begin
        mismatched++;
        $display("FAIL idle_cycle%0d: got mode=%b allow=%b want mode=0 allow=1", i, schedIf.channelMode, schedIf.casAllow);
      end
    end
  endtask

  task automatic test_high_wm();
    schedIf.rdCount = 6'd5;
    schedIf.wrCount = 6'd23;
    #1;
    compared++;
    if (schedIf.casAllow !== 1'b1) begin
      mismatched++; $display("FAIL hwm_below: got allow=%b want 1", schedIf.casAllow);
    end
    step();
    schedIf.wrCount = 6'd24;
    #1;
    compared++;
    if (schedIf.casAllow !== 1'b0) begin
      mismatched++; $display("FAIL hwm_switch_cycle: got allow=%b want 0", schedIf.casAllow);
    end
    step();
    schedIf.DQTurnaroundFree = 1'b0;
    #1;
    compared++;
    if (schedIf.channelMode !== 1'b1) begin
      mismatched++; $display("FAIL hwm_mode: got %b want 1", schedIf.channelMode);
    end
    for (int i = 2; i <= 6; i++) begin
      step(); #1;
      compared++;
      if (schedIf.casAllow !== 1'b0) begin
        mismatched++; $display("FAIL hwm_turnaround_n%0d: got allow=%b want 0", i, schedIf.casAllow);
      end
    end
    step();
    schedIf.DQTurnaroundFree = 1'b1;
    #1;
    compared++;
    if (schedIf.casAllow !== 1'b0) begin
      mismatched++; $display("FAIL hwm_n7: got allow=%b want 0", schedIf.casAllow);
    end
    step(); #1;
    compared++;
    if (schedIf.casAllow !== 1'b1 || schedIf.channelMode !== 1'b1) begin
      mismatched++;
      $display("FAIL hwm_first_cas_n8: got allow=%b mode=%b want 1 1", schedIf.casAllow, schedIf.channelMode);
    end
  endtask

  // Called in WRITE; issues 16 write CAS, expects the WR->RD switch right after.
  task automatic test_burst(input logic [1:0] wrRank, input logic [1:0] rdRank, input logic expRc);
    schedIf.rdCount = 6'd3;
    schedIf.wrCount = 6'd20;
    schedIf.nextRdRank = rdRank;
    for (int i = 0; i < 16; i++) begin
      schedIf.casIssued = 1'b1;
      schedIf.casRank = wrRank;
      #1;
      compared++;
      if (schedIf.casAllow !== 1'b1) begin
        mismatched++; $display("FAIL burst_allow%0d: got %b want 1", i, schedIf.casAllow);
      end
      step();
    end
    schedIf.casIssued = 1'b0;
    #1;
    compared++;
    if (schedIf.casAllow !== 1'b0) begin
      mismatched++; $display("FAIL burst_limit: got allow=%b want 0", schedIf.casAllow);
    end
    step(); #1;
    compared++;
    if (schedIf.channelMode !== 1'b0 || schedIf.rankChanged !== expRc) begin
      mismatched++;
      $display("FAIL burst_wr2rd: got mode=%b rc=%b want 0 %b", schedIf.channelMode, schedIf.rankChanged, expRc);
    end
    step(); step(); step(); #1;
    compared++;
    if (schedIf.casAllow !== 1'b1 || schedIf.rankChanged !== expRc) begin
      mismatched++;
      $display("FAIL rank_hold: got allow=%b rc=%b want 1 %b", schedIf.casAllow, schedIf.rankChanged, expRc);
    end
  endtask

  // Called in READ; forces RD->WR via the high watermark and lands in WRITE.
  task automatic enter_write();
    schedIf.wrCount = 6'd24;
    #1;
    compared++;
    if (schedIf.casAllow !== 1'b0) begin
      mismatched++; $display("FAIL enter_switch: got allow=%b want 0", schedIf.casAllow);
    end
    step(); #1;
    compared++;
    if (schedIf.channelMode !== 1'b1 || schedIf.rankChanged !== 1'b0) begin
      mismatched++;
      $display("FAIL enter_mode: got mode=%b rc=%b want 1 0", schedIf.channelMode, schedIf.rankChanged);
    end
    step(); step(); #1;
    compared++;
    if (schedIf.casAllow !== 1'b1) begin
      mismatched++; $display("FAIL enter_write_allow: got %b want 1", schedIf.casAllow);
    end
  endtask

  task automatic test_low_wm();
    schedIf.rdCount = '0;
    schedIf.wrCount = '0;
    #1;
    compared++;
    if (schedIf.casAllow !== 1'b1) begin
      mismatched++; $display("FAIL empty_hold: got allow=%b want 1", schedIf.casAllow);
    end
    step(); #1;
    compared++;
    if (schedIf.channelMode !== 1'b1) begin
      mismatched++; $display("FAIL empty_mode: got %b want 1", schedIf.channelMode);
    end
    schedIf.rdCount = 6'd3;
    schedIf.wrCount = 6'd9;
    #1;
    compared++;
    if (schedIf.casAllow !== 1'b1) begin
      mismatched++; $display("FAIL lwm_above: got allow=%b want 1", schedIf.casAllow);
    end
    step();
    schedIf.wrCount = 6'd8;
    #1;
    compared++;
    if (schedIf.casAllow !== 1'b0) begin
      mismatched++; $display("FAIL lwm_switch: got allow=%b want 0", schedIf.casAllow);
    end
    step(); #1;
    compared++;
    if (schedIf.channelMode !== 1'b0) begin
      mismatched++; $display("FAIL lwm_mode: got %b want 0", schedIf.channelMode);
    end
  endtask

  task automatic test_starvation();
    int lateAllow;
    lateAllow = 0;
    schedIf.rdCount = 6'd10;
    schedIf.wrCount = '0;
    step(); step(); #1;
    compared++;
    if (schedIf.casAllow !== 1'b1 || schedIf.channelMode !== 1'b0) begin
      mismatched++;
      $display("FAIL starve_read: got allow=%b mode=%b want 1 0", schedIf.casAllow, schedIf.channelMode);
    end
    step();
    schedIf.wrCount = 6'd1;
    for (int k = 0; k < 255; k++) begin
      #1;
      compared++;
      if (schedIf.casAllow !== 1'b1) begin
        mismatched++; $display("FAIL starve_early_k%0d: got allow=%b want 1", k, schedIf.casAllow);
      end
      step();
    end
    #1;
    compared++;
    if (schedIf.casAllow !== 1'b0 || schedIf.channelMode !== 1'b0) begin
      mismatched++;
      $display("FAIL starve_switch: got allow=%b mode=%b want 0 0", schedIf.casAllow, schedIf.channelMode);
    end
    step(); #1;
    compared++;
    if (schedIf.channelMode !== 1'b1) begin
      mismatched++; $display("FAIL starve_mode: got %b want 1", schedIf.channelMode);
    end
  endtask

  // Called one cycle after RD->WR edge; last accepted write rank was 2.
  task automatic test_protocol_error();
    schedIf.casIssued = 1'b1;
    schedIf.casRank = 2'd3;
    #1;
    compared++;
    if (schedIf.casAllow !== 1'b0) begin
      mismatched++; $display("FAIL perr_allow: got %b want 0", schedIf.casAllow);
    end
    step();
    schedIf.casIssued = 1'b0;
    #1;
    compared++;
    if (schedIf.protocolError !== 1'b1) begin
      mismatched++; $display("FAIL perr_flag: got %b want 1", schedIf.protocolError);
    end
    compared++;
    if (dut.wrBurst !== 5'd0 || dut.lastWrRank !== 2'd2) begin
      mismatched++;
      $display("FAIL perr_counters: got burst=%0d rank=%0d want 0 2", dut.wrBurst, dut.lastWrRank);
    end
  endtask

  task automatic test_reset_mid_turnaround();
    step();
    schedIf.DQTurnaroundFree = 1'b0;
    #1;
    compared++;
    if (schedIf.casAllow !== 1'b0 || schedIf.channelMode !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_write_switch: got allow=%b mode=%b want 0 1", schedIf.casAllow, schedIf.channelMode);
    end
    step(); #1;
    compared++;
    if (dut.state !== 2'd3 || schedIf.channelMode !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_in_wr2rd: got state=%0d mode=%b want 3 0", dut.state, schedIf.channelMode);
    end
    step();
    rst = 1'b0;
    #1;
    compared++;
    if (dut.state !== 2'd0 || schedIf.channelMode !== 1'b0 || schedIf.protocolError !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: got state=%0d mode=%b perr=%b want 0 0 0", dut.state, schedIf.channelMode, schedIf.protocolError);
    end
    schedIf.DQTurnaroundFree = 1'b1;
    schedIf.rdCount = '0;
    schedIf.wrCount = '0;
    step();
    rst = 1'b1;
    step(); #1;
    compared++;
    if (schedIf.casAllow !== 1'b1 || schedIf.channelMode !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset: got allow=%b mode=%b want 1 0", schedIf.casAllow, schedIf.channelMode);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_high_wm();
    test_burst(2'd1, 2'd2, 1'b1);
    enter_write();
    test_burst(2'd2, 2'd2, 1'b0);
    enter_write();
    test_low_wm();
    test_starvation();
    test_protocol_error();
    test_reset_mid_turnaround();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
